// File: rtl/simon_serial_ctrl_pkg.sv
// Shared constants, phase codes and FSM state type for the Simon128/128
// bit-serial sequencer.
package simon_serial_ctrl_pkg;

  localparam int unsigned SIMON_BLOCK_SIZE = 128;
  localparam int unsigned SIMON_KEY_SIZE   = 128;
  localparam int unsigned SIMON_WORD_SIZE  = 64;
  localparam int unsigned SIMON_NUM_ROUNDS = 68;
  localparam int unsigned SIMON_BC_W       = 6;
  localparam int unsigned SIMON_RC_W       = 7;
  localparam int unsigned SIMON_CNT_W      = 8;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SHIFT = 2'd1;
  localparam logic [1:0] PH_KEY   = 2'd2;
  localparam logic [1:0] PH_RUN   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_PT,
    ST_LOAD_KEY,
    ST_RUN,
    ST_UNLOAD,
    ST_FIN
  } state_e;

  // Phase code seen by the key schedule and round datapath.
  function automatic logic [1:0] phase_code(input state_e s);
    logic [1:0] ph;
    ph = PH_IDLE;
    case (s)
      ST_LOAD_PT:  ph = PH_SHIFT;
      ST_LOAD_KEY: ph = PH_KEY;
      ST_RUN:      ph = PH_RUN;
      ST_UNLOAD:   ph = PH_SHIFT;
      default:     ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/simon_phase_counter.sv
// Bit position, phase-length and round counters; flags the last cycle of
// the current phase.
module simon_phase_counter
  import simon_serial_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = SIMON_WORD_SIZE,
  parameter int unsigned NUM_ROUNDS = SIMON_NUM_ROUNDS,
  parameter int unsigned BC_W       = SIMON_BC_W,
  parameter int unsigned RC_W       = SIMON_RC_W,
  parameter int unsigned CNT_W      = SIMON_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             count_rounds_i,
  input  logic [CNT_W-1:0] wrap_len_i,
  output logic [BC_W-1:0]  bit_counter_o,
  output logic [RC_W-1:0]  round_o,
  output logic             last_o
);

  logic [BC_W-1:0]  bc_q, bc_d;
  logic [RC_W-1:0]  round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_end;

  assign word_end = (bc_q == BC_W'(WORD_SIZE - 1));

  // Next counter values: clear wins, otherwise advance while enabled.
  always_comb begin
    bc_d    = bc_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      bc_d    = '0;
      round_d = '0;
      cnt_d   = '0;
    end else if (enable_i) begin
      bc_d  = word_end ? '0 : bc_q + BC_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
      if (count_rounds_i && word_end) begin
        round_d = round_q + RC_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q    <= '0;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      bc_q    <= bc_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  // RUN is too long for the 8-bit phase counter, so it ends on round/bit.
  always_comb begin
    if (count_rounds_i) begin
      last_o = word_end && (round_q == RC_W'(NUM_ROUNDS - 1));
    end else begin
      last_o = (cnt_q == (wrap_len_i - CNT_W'(1)));
    end
  end

  assign bit_counter_o = bc_q;
  assign round_o       = round_q;

endmodule

// File: rtl/simon_serial_ctrl.sv
// Top-level sequencer for the bit-serial Simon128/128 core: phase codes,
// bit position, serial input steering and ciphertext output framing.
module simon_serial_ctrl
  import simon_serial_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = SIMON_BLOCK_SIZE,
  parameter int unsigned KEY_SIZE   = SIMON_KEY_SIZE,
  parameter int unsigned WORD_SIZE  = SIMON_WORD_SIZE,
  parameter int unsigned NUM_ROUNDS = SIMON_NUM_ROUNDS,
  parameter int unsigned BC_W       = SIMON_BC_W,
  parameter int unsigned RC_W       = SIMON_RC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            din,
  input  logic            ct_bit,
  output logic            data_in,
  output logic [1:0]      data_rdy,
  output logic [BC_W-1:0] bit_counter,
  output logic            dout,
  output logic            dout_valid,
  output logic            busy,
  output logic            done
);

  state_e                 state_q, state_d;
  logic [SIMON_CNT_W-1:0] wrap_len;
  logic                   phase_last;
  logic                   cnt_clear;
  logic                   cnt_enable;
  logic [RC_W-1:0]        round;
  logic                   dout_q, dout_valid_q;

  simon_phase_counter #(
    .WORD_SIZE  (WORD_SIZE),
    .NUM_ROUNDS (NUM_ROUNDS),
    .BC_W       (BC_W),
    .RC_W       (RC_W),
    .CNT_W      (SIMON_CNT_W)
  ) u_phase (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (cnt_clear),
    .enable_i       (cnt_enable),
    .count_rounds_i (state_q == ST_RUN),
    .wrap_len_i     (wrap_len),
    .bit_counter_o  (bit_counter),
    .round_o        (round),
    .last_o         (phase_last)
  );

  // Next-state logic and phase-length selection.
  always_comb begin
    state_d  = state_q;
    wrap_len = '0;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_LOAD_PT;
      ST_LOAD_PT: begin
        wrap_len = SIMON_CNT_W'(BLOCK_SIZE);
        if (phase_last) state_d = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        wrap_len = SIMON_CNT_W'(KEY_SIZE);
        if (phase_last) state_d = ST_RUN;
      end
      ST_RUN:      if (phase_last) state_d = ST_UNLOAD;
      ST_UNLOAD: begin
        wrap_len = SIMON_CNT_W'(BLOCK_SIZE);
        if (phase_last) state_d = ST_FIN;
      end
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counters restart on every state entry and only run in active phases.
  always_comb begin
    cnt_clear  = (state_d != state_q);
    cnt_enable = (state_q == ST_LOAD_PT) || (state_q == ST_LOAD_KEY) ||
                 (state_q == ST_RUN)     || (state_q == ST_UNLOAD);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Ciphertext output is the datapath bit delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= (state_q == ST_UNLOAD) ? ct_bit : 1'b0;
      dout_valid_q <= (state_q == ST_UNLOAD);
    end
  end

  // Combinational outputs decoded from state.
  always_comb begin
    data_rdy = phase_code(state_q);
    data_in  = ((state_q == ST_LOAD_PT) || (state_q == ST_LOAD_KEY)) ? din : 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_FIN);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_simon_serial_ctrl.sv
module tb_simon_serial_ctrl;

  localparam int L_PT    = 128;
  localparam int L_KEY   = 128;
  localparam int L_RUN   = 68 * 64;
  localparam int L_UNL   = 128;
  localparam int T_KEY   = L_PT + 1;
  localparam int T_RUN   = L_PT + L_KEY + 1;
  localparam int T_UNL   = T_RUN + L_RUN;
  localparam int T_FIN   = T_UNL + L_UNL;

  logic       clk = 1'b0;
  logic       rst_n, start, din, ct_bit;
  logic       data_in, dout, dout_valid, busy, done;
  logic [1:0] data_rdy;
  logic [5:0] bit_counter;

  int tests = 0;
  int fails = 0;
  int cur_k = 0;

  simon_serial_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .din         (din),
    .ct_bit      (ct_bit),
    .data_in     (data_in),
    .data_rdy    (data_rdy),
    .bit_counter (bit_counter),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [1:0] rdy;
    int         bc;
    logic       bsy;
    logic       dn;
    logic       dv;
  } chk_t;

  chk_t tbl[$];

  function automatic logic [12:0] obs();
    return {data_rdy, bit_counter, busy, done, dout_valid, dout, data_in};
  endfunction

  // Expected outputs in cycle k after the start sample (k=0: idle).
  function automatic logic [12:0] model(input int k, input logic d, input logic ctp);
    logic [1:0] r;
    int         bc;
    logic       b, dn, dv, dt, di;
    r = 2'd0; bc = 0; b = 0; dn = 0; dv = 0; dt = 0; di = 0;
    if (k >= 1 && k < T_KEY) begin
      r = 2'd1; bc = (k - 1) % 64; b = 1; di = d;
    end else if (k >= T_KEY && k < T_RUN) begin
      r = 2'd2; bc = (k - T_KEY) % 64; b = 1; di = d;
    end else if (k >= T_RUN && k < T_UNL) begin
      r = 2'd3; bc = (k - T_RUN) % 64; b = 1;
    end else if (k >= T_UNL && k < T_FIN) begin
      r = 2'd1; bc = (k - T_UNL) % 64; b = 1;
      dv = (k > T_UNL); dt = dv ? ctp : 1'b0;
    end else if (k == T_FIN) begin
      b = 1; dn = 1; dv = 1; dt = ctp;
    end
    return {r, 6'(bc), b, dn, dv, dt, di};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s k=%0d actual=%0h expected=%0h", name, cur_k, act, exp);
    end
  endtask

  // One encryption from a start pulse; optional extra start pulses and abort.
  task automatic run_enc(input int pulse_a, input int pulse_b, input int abort_k);
    logic ct_prev;
    ct_prev = 1'b0;
    cur_k  = 0;
    start  = 1'b1;
    din    = 1'($urandom);
    ct_bit = 1'($urandom);
    @(negedge clk);
    check("idle_before_start", 32'(obs()), 32'(model(0, din, 1'b0)));
    @(posedge clk); #1;
    for (int k = 1; k <= T_FIN; k++) begin
      cur_k  = k;
      din    = 1'($urandom);
      ct_bit = 1'($urandom);
      start  = (k == pulse_a) || (k == pulse_b);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs()), 32'(model(0, din, 1'b0)));
        check("async_reset_round", 32'(dut.u_phase.round_q), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held_outputs", 32'(obs()), 32'(model(0, din, 1'b0)));
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      check("cycle", 32'(obs()), 32'(model(k, din, ct_prev)));
      if (k >= T_RUN && k < T_UNL)
        check("round", 32'(dut.u_phase.round_q), 32'((k - T_RUN) / 64));
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].k == k) begin
          check("tbl_rdy",  32'(data_rdy),    32'(tbl[i].rdy));
          check("tbl_bc",   32'(bit_counter), 32'(tbl[i].bc));
          check("tbl_busy", 32'(busy),        32'(tbl[i].bsy));
          check("tbl_done", 32'(done),        32'(tbl[i].dn));
          check("tbl_dv",   32'(dout_valid),  32'(tbl[i].dv));
        end
      end
      ct_prev = ct_bit;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    // Boundary cycles counted from the start sample edge.
    tbl.push_back('{1,    2'd1, 0,  1, 0, 0});
    tbl.push_back('{64,   2'd1, 63, 1, 0, 0});
    tbl.push_back('{65,   2'd1, 0,  1, 0, 0});
    tbl.push_back('{128,  2'd1, 63, 1, 0, 0});
    tbl.push_back('{129,  2'd2, 0,  1, 0, 0});
    tbl.push_back('{256,  2'd2, 63, 1, 0, 0});
    tbl.push_back('{257,  2'd3, 0,  1, 0, 0});
    tbl.push_back('{4608, 2'd3, 63, 1, 0, 0});
    tbl.push_back('{4609, 2'd1, 0,  1, 0, 0});
    tbl.push_back('{4610, 2'd1, 1,  1, 0, 1});
    tbl.push_back('{4736, 2'd1, 63, 1, 0, 1});
    tbl.push_back('{4737, 2'd0, 0,  1, 1, 1});

    rst_n = 1'b0; start = 1'b0; din = 1'b0; ct_bit = 1'b0;
    #12;
    cur_k = -1;
    check("reset_state", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_enc(0, 0, 0);
    run_enc(150, 1000, 0);
    run_enc(0, 0, T_RUN + 30 * 64 + 10);
    run_enc(0, 0, 0);
    run_enc(0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      cur_k = 0;
      din = 1'($urandom);
      ct_bit = 1'($urandom);
      @(negedge clk);
      check("idle_after", 32'(obs()), 32'(model(0, din, 1'b0)));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
